apb_bridge_core: RTL

Parametrised AXI4-Lite slave to APB4 master bridge that drives up to NSLAVES APB completers through one-hot select decode. It sits between the AXI4-Lite interconnect and the peripheral APB segment. It replaces the FIFO-coupled converter with a single-outstanding, fully registered transfer engine that adds:
- read/write fairness arbitration
- address decode with DECERR
- an optional APB wait-state timeout

---
 rtl/apb_bridge_core_if.sv | 58 +++++
 rtl/apb_bridge_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_core_if.sv
// rtl/apb_bridge_core_if.sv - AXI4-Lite and APB4 signal bundle for apb_bridge_core
interface apb_bridge_core_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int NSLAVES   = 4
) ();
    logic [ADDRWIDTH-1:0]         awaddr;
    logic [2:0]                   awprot;
    logic                         awvalid;
    logic                         awready;
    logic [DATAWIDTH-1:0]         wdata;
    logic [DATAWIDTH/8-1:0]       wstrb;
    logic                         wvalid;
    logic                         wready;
    logic [1:0]                   bresp;
    logic                         bvalid;
    logic                         bready;
    logic [ADDRWIDTH-1:0]         araddr;
    logic [2:0]                   arprot;
    logic                         arvalid;
    logic                         arready;
    logic [DATAWIDTH-1:0]         rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;
    logic [ADDRWIDTH-1:0]         paddr;
    logic [2:0]                   pprot;
    logic                         pwrite;
    logic [DATAWIDTH-1:0]         pwdata;
    logic [DATAWIDTH/8-1:0]       pstrb;
    logic [NSLAVES-1:0]           psel;
    logic                         penable;
    logic [NSLAVES*DATAWIDTH-1:0] prdata;
    logic [NSLAVES-1:0]           pready;
    logic [NSLAVES-1:0]           pslverr;

    // Bridge view: AXI4-Lite completer on one side, APB4 requester on the other
    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        output paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
        input  prdata, pready, pslverr
    );

    // Environment view: AXI4-Lite requester and the APB completers
    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_bridge_core.sv
// rtl/apb_bridge_core.sv - single-outstanding AXI4-Lite to APB4 bridge, optional APB_TIMEOUT_EN
module apb_bridge_core #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int NSLAVES   = 4,
    parameter int SLV_LSB   = 12,
    parameter int TIMEOUT   = 16
) (
    input logic              clk,
    input logic              rst,
    apb_bridge_core_if.slave bus
);
    localparam int IDXW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [IDXW:0] NS_L = (IDXW+1)'(NSLAVES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic                    r_last_wr;
    logic                    r_is_wr;
    logic [ADDRWIDTH-1:0]    r_paddr;
    logic [2:0]              r_pprot;
    logic                    r_pwrite;
    logic [DATAWIDTH-1:0]    r_pwdata;
    logic [DATAWIDTH/8-1:0]  r_pstrb;
    logic [NSLAVES-1:0]      r_psel;
    logic                    r_penable;
    logic [DATAWIDTH-1:0]    r_rdata;
    logic [1:0]              r_bresp;
    logic [1:0]              r_rresp;
    logic                    r_bvalid;
    logic                    r_rvalid;

    logic                    w_idle;
    logic                    w_wr_cand;
    logic                    w_rd_cand;
    logic                    w_grant_wr;
    logic                    w_grant_rd;
    logic                    w_grant;
    logic [ADDRWIDTH-1:0]    w_addr;
    logic [IDXW-1:0]         w_idx;
    logic                    w_decerr;
    logic [NSLAVES-1:0]      w_sel_dec;
    logic                    w_pready;
    logic                    w_pslverr;
    logic [DATAWIDTH-1:0]    w_prdata;
    logic [1:0]              w_acc_resp;
    logic                    w_resp_ack;
    logic                    w_timeout;

    // Grants are only offered from IDLE and never while reset is held
    assign w_idle     = (r_state == S_IDLE) && rst;
    assign w_wr_cand  = bus.awvalid && bus.wvalid;
    assign w_rd_cand  = bus.arvalid;
    assign w_grant_wr = w_idle && w_wr_cand && (!w_rd_cand || !r_last_wr);
    assign w_grant_rd = w_idle && w_rd_cand && (!w_wr_cand || r_last_wr);
    assign w_grant    = w_grant_wr || w_grant_rd;
    assign w_addr     = w_grant_wr ? bus.awaddr : bus.araddr;

    generate
        if (NSLAVES > 1) begin : g_idx
            assign w_idx = w_addr[SLV_LSB +: IDXW];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    assign w_decerr = ({1'b0, w_idx} >= NS_L);

    // One-hot decode of the slave index for the SETUP-phase select
    always_comb begin
        w_sel_dec = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (int'(w_idx) == i) begin
                w_sel_dec[i] = 1'b1;
            end
        end
    end

    // Only the selected completer's response lines are observed
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (r_psel[i]) begin
                w_pready  = w_pready  | bus.pready[i];
                w_pslverr = w_pslverr | bus.pslverr[i];
                w_prdata  = w_prdata  | bus.prdata[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign w_acc_resp = (w_pready && !w_pslverr) ? 2'b00 : 2'b10;
    assign w_resp_ack = r_is_wr ? (r_bvalid && bus.bready) : (r_rvalid && bus.rready);

`ifdef APB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_cnt;

    // pready takes priority over an expiring count in the same cycle
    assign w_timeout = (r_state == S_ACCESS) && !w_pready && (r_cnt == CW'(TIMEOUT - 1));

    // Count ACCESS cycles spent waiting for pready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS && !w_pready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_state_nx = w_decerr ? S_RESP : S_SETUP;
            S_SETUP:  w_state_nx = S_ACCESS;
            S_ACCESS: if (w_pready || w_timeout) w_state_nx = S_RESP;
            S_RESP:   if (w_resp_ack) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Transfer capture, APB phase control and AXI response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_wr <= 1'b0;
            r_is_wr   <= 1'b0;
            r_paddr   <= '0;
            r_pprot   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_rdata   <= '0;
            r_bresp   <= '0;
            r_rresp   <= '0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_is_wr   <= w_grant_wr;
                        r_last_wr <= w_grant_wr;
                        r_pwrite  <= w_grant_wr;
                        r_paddr   <= w_addr;
                        r_pprot   <= w_grant_wr ? bus.awprot : bus.arprot;
                        if (w_grant_wr) begin
                            r_pwdata <= bus.wdata;
                            r_pstrb  <= bus.wstrb;
                        end else begin
                            r_pstrb  <= '0;
                        end
                        if (w_decerr) begin
                            if (w_grant_wr) begin
                                r_bvalid <= 1'b1;
                                r_bresp  <= 2'b11;
                            end else begin
                                r_rvalid <= 1'b1;
                                r_rresp  <= 2'b11;
                                r_rdata  <= '0;
                            end
                        end else begin
                            r_psel <= w_sel_dec;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (w_pready || w_timeout) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        if (r_is_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_acc_resp;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= w_acc_resp;
                            r_rdata  <= w_pready ? w_prdata : '0;
                        end
                    end
                end
                S_RESP: begin
                    if (w_resp_ack) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.awready = w_grant_wr;
    assign bus.wready  = w_grant_wr;
    assign bus.arready = w_grant_rd;
    assign bus.bresp   = r_bresp;
    assign bus.bvalid  = r_bvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;
    assign bus.rvalid  = r_rvalid;
    assign bus.paddr   = r_paddr;
    assign bus.pprot   = r_pprot;
    assign bus.pwrite  = r_pwrite;
    assign bus.pwdata  = r_pwdata;
    assign bus.pstrb   = r_pstrb;
    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
endmodule
